llm_light_driver: RTL and testbench



---
 rtl/llm_light_driver.sv | 208 ++++++++++++++++++++
 tb/tb_llm_light_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/llm_light_driver.sv
// Traffic-light style sequencer driving green/yellow/red light lines.
// Runs GREEN -> YELLOW -> RED for a latched number of rounds (0 = run until
// stop), each phase lasting its latched duration. An optional build macro
// inserts one dark GAP cycle between consecutive colour phases.
module llm_light_driver #(
    parameter int TW = 6,
    parameter int CW = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stop,
    input  logic [TW-1:0] dur_green,
    input  logic [TW-1:0] dur_yellow,
    input  logic [TW-1:0] dur_red,
    input  logic [CW-1:0] cycles,
    output logic          green,
    output logic          yellow,
    output logic          red,
    output logic          busy,
    output logic          done,
    output logic [TW-1:0] timer,
    output logic [1:0]    phase
);

`ifdef LLM_DRV_GAP_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_RED    = 3'd3,
        S_GAP    = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_RED    = 3'd3
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] dur_g_q, dur_g_d;
    logic [TW-1:0] dur_y_q, dur_y_d;
    logic [TW-1:0] dur_r_q, dur_r_d;
    logic [CW-1:0] rounds_q, rounds_d;
    logic          cont_q, cont_d;
    logic          done_d;
    logic          advance;
    state_t        target;
`ifdef LLM_DRV_GAP_EN
    state_t        gap_next_q, gap_next_d;
`endif

    // Timer preload for a phase of d cycles; a zero duration behaves as one cycle.
    function automatic logic [TW-1:0] ld(input logic [TW-1:0] d);
        return (d == '0) ? '0 : d - TW'(1);
    endfunction

    // Timer preload for whichever colour is being entered.
    function automatic logic [TW-1:0] load_for(input state_t s,
                                               input logic [TW-1:0] g,
                                               input logic [TW-1:0] y,
                                               input logic [TW-1:0] r);
        case (s)
            S_YELLOW: return ld(y);
            S_RED:    return ld(r);
            default:  return ld(g);
        endcase
    endfunction

    // Encoding of the externally visible phase code; GAP reads as 0.
    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            S_GREEN:  return 2'd1;
            S_YELLOW: return 2'd2;
            S_RED:    return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

    // Next-state logic: phase timing, round counting, stop override.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        dur_g_d  = dur_g_q;
        dur_y_d  = dur_y_q;
        dur_r_d  = dur_r_q;
        rounds_d = rounds_q;
        cont_d   = cont_q;
        done_d   = 1'b0;
        advance  = 1'b0;
        target   = S_IDLE;
`ifdef LLM_DRV_GAP_EN
        gap_next_d = gap_next_q;
`endif
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (start && !stop) begin
                    dur_g_d  = dur_green;
                    dur_y_d  = dur_yellow;
                    dur_r_d  = dur_red;
                    rounds_d = cycles;
                    cont_d   = (cycles == '0);
                    state_d  = S_GREEN;
                    timer_d  = ld(dur_green);
                end
            end
            S_GREEN: begin
                advance = (timer_q == '0);
                target  = S_YELLOW;
            end
            S_YELLOW: begin
                advance = (timer_q == '0);
                target  = S_RED;
            end
            S_RED: begin
                advance = (timer_q == '0);
                // A counted run ends when the round just finishing is the last one.
                target  = (!cont_q && rounds_q <= CW'(1)) ? S_IDLE : S_GREEN;
            end
`ifdef LLM_DRV_GAP_EN
            S_GAP: begin
                state_d = gap_next_q;
                timer_d = load_for(gap_next_q, dur_g_q, dur_y_q, dur_r_q);
            end
`endif
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        if (state_q == S_GREEN || state_q == S_YELLOW || state_q == S_RED) begin
            if (!advance) begin
                timer_d = timer_q - TW'(1);
            end else if (target == S_IDLE) begin
                state_d = S_IDLE;
                timer_d = '0;
                done_d  = 1'b1;
            end else begin
                if (state_q == S_RED && !cont_q) begin
                    rounds_d = rounds_q - CW'(1);
                end
`ifdef LLM_DRV_GAP_EN
                state_d    = S_GAP;
                gap_next_d = target;
                timer_d    = '0;
`else
                state_d = target;
                timer_d = load_for(target, dur_g_q, dur_y_q, dur_r_q);
`endif
            end
        end

        // Abort from any active state; no done pulse on this path.
        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            timer_d = '0;
            done_d  = 1'b0;
        end
    end

    // State and all outputs registered together so outputs never see inputs combinationally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            dur_g_q  <= '0;
            dur_y_q  <= '0;
            dur_r_q  <= '0;
            rounds_q <= '0;
            cont_q   <= 1'b0;
`ifdef LLM_DRV_GAP_EN
            gap_next_q <= S_IDLE;
`endif
            green    <= 1'b0;
            yellow   <= 1'b0;
            red      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timer    <= '0;
            phase    <= 2'd0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            dur_g_q  <= dur_g_d;
            dur_y_q  <= dur_y_d;
            dur_r_q  <= dur_r_d;
            rounds_q <= rounds_d;
            cont_q   <= cont_d;
`ifdef LLM_DRV_GAP_EN
            gap_next_q <= gap_next_d;
`endif
            green    <= (state_d == S_GREEN);
            yellow   <= (state_d == S_YELLOW);
            red      <= (state_d == S_RED);
            busy     <= (state_d != S_IDLE);
            done     <= done_d;
            timer    <= timer_d;
            phase    <= phase_of(state_d);
        end
    end

endmodule

// File: tb/tb_llm_light_driver.sv
// Bench for llm_light_driver: expected per-cycle light/timer/busy/done trace is
// generated from phase durations and round counts, then compared cycle by cycle.
module tb_llm_light_driver;
    localparam int TW = 6;
    localparam int CW = 4;
`ifdef LLM_DRV_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic          clock;
    logic          reset_n;
    logic          start;
    logic          stop;
    logic [TW-1:0] dur_green;
    logic [TW-1:0] dur_yellow;
    logic [TW-1:0] dur_red;
    logic [CW-1:0] cycles;
    logic          green;
    logic          yellow;
    logic          red;
    logic          busy;
    logic          done;
    logic [TW-1:0] timer;
    logic [1:0]    phase;

    typedef struct packed {
        logic [1:0]    ph;
        logic [TW-1:0] tm;
        logic          bz;
        logic          dn;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    llm_light_driver #(.TW(TW), .CW(CW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
        .dur_green(dur_green), .dur_yellow(dur_yellow), .dur_red(dur_red),
        .cycles(cycles), .green(green), .yellow(yellow), .red(red),
        .busy(busy), .done(done), .timer(timer), .phase(phase)
    );

    always #5 clock = ~clock;

    function automatic exp_t idle_e(input logic dn);
        exp_t e;
        e.ph = 2'd0; e.tm = '0; e.bz = 1'b0; e.dn = dn;
        return e;
    endfunction

    // Expected trace: each round is G,Y,R with N cycles each (0 counts as 1),
    // timer counting N-1 down to 0; optional dark cycle between colours; a
    // counted run ends with one done cycle and then plain IDLE.
    function automatic void build(input int dg, input int dy, input int dr,
                                  input int cyc, input int maxr);
        int durs[3];
        int nr;
        int n;
        exp_t e;
        durs[0] = dg; durs[1] = dy; durs[2] = dr;
        nr = (cyc == 0) ? maxr : cyc;
        exp_q.delete();
        for (int r = 0; r < nr; r++) begin
            for (int p = 0; p < 3; p++) begin
                n = (durs[p] == 0) ? 1 : durs[p];
                if (GAP_EN && !(r == 0 && p == 0)) begin
                    e.ph = 2'd0; e.tm = '0; e.bz = 1'b1; e.dn = 1'b0;
                    exp_q.push_back(e);
                end
                for (int k = 0; k < n; k++) begin
                    e.ph = 2'(p + 1); e.tm = TW'(n - 1 - k); e.bz = 1'b1; e.dn = 1'b0;
                    exp_q.push_back(e);
                end
            end
        end
        if (cyc != 0) begin
            exp_q.push_back(idle_e(1'b1));
            exp_q.push_back(idle_e(1'b0));
        end
    endfunction

    task automatic chk(input string tag, input exp_t e);
        logic [2:0] lx;
        case (e.ph)
            2'd1:    lx = 3'b100;
            2'd2:    lx = 3'b010;
            2'd3:    lx = 3'b001;
            default: lx = 3'b000;
        endcase
        tests++;
        assert (phase === e.ph) else begin
            fails++; $error("FAIL %s phase got %0d expected %0d", tag, phase, e.ph);
        end
        tests++;
        assert ({green, yellow, red} === lx) else begin
            fails++; $error("FAIL %s lights(gyr) got %b expected %b", tag, {green, yellow, red}, lx);
        end
        tests++;
        assert (timer === e.tm) else begin
            fails++; $error("FAIL %s timer got %0d expected %0d", tag, timer, e.tm);
        end
        tests++;
        assert (busy === e.bz) else begin
            fails++; $error("FAIL %s busy got %b expected %b", tag, busy, e.bz);
        end
        tests++;
        assert (done === e.dn) else begin
            fails++; $error("FAIL %s done got %b expected %b", tag, done, e.dn);
        end
        $display("[TB] %s: ph=%0d gyr=%b timer=%0d busy=%b done=%b", tag, phase,
                 {green, yellow, red}, timer, busy, done);
    endtask

    task automatic apply_start(input int dg, input int dy, input int dr, input int cyc);
        dur_green  = TW'(dg);
        dur_yellow = TW'(dy);
        dur_red    = TW'(dr);
        cycles     = CW'(cyc);
        start      = 1'b1;
    endtask

    // Walk the whole expected trace; with noise, re-pulse start and scramble
    // the configuration inputs while busy (all must be ignored).
    task automatic run_q(input string tag, input bit noise);
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clock); #1;
            start = 1'b0;
            chk(tag, e);
            if (noise && e.bz) begin
                start      = 1'($urandom);
                dur_green  = TW'($urandom);
                dur_yellow = TW'($urandom);
                dur_red    = TW'($urandom);
                cycles     = CW'($urandom);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   dg, dy, dr, cy, n;
        clock = 1'b0; reset_n = 1'b1; start = 1'b0; stop = 1'b0;
        dur_green = '0; dur_yellow = '0; dur_red = '0; cycles = '0;

        // Reset state
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 chk("reset", idle_e(1'b0));
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1 chk("reset_rel", idle_e(1'b0));

        // Basic single round 3/2/4
        build(3, 2, 4, 1, 0); apply_start(3, 2, 4, 1); run_q("basic", 1'b0);

        // Duration boundaries
        build(0, 1, 2, 1, 0); apply_start(0, 1, 2, 1); run_q("dur0", 1'b0);
        build(63, 2, 1, 1, 0); apply_start(63, 2, 1, 1); run_q("dur63", 1'b0);

        // Short multi-round pattern (dark cycles appear in the gap build)
        build(1, 1, 1, 2, 0); apply_start(1, 1, 1, 2); run_q("pat111", 1'b0);

        // Random runs with start re-pulsed and inputs scrambled while busy
        repeat (6) begin
            dg = int'($urandom_range(0, 7));
            dy = int'($urandom_range(0, 7));
            dr = int'($urandom_range(0, 7));
            cy = int'($urandom_range(1, 3));
            build(dg, dy, dr, cy, 0); apply_start(dg, dy, dr, cy); run_q("rand", 1'b1);
        end

        // Continuous mode: 150 checked cycles, then stop in YELLOW
        build(5, 4, 6, 0, 14); apply_start(5, 4, 6, 0);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clock); #1;
            start = 1'b0;
            chk("cont", e);
            n++;
            if (n >= 150 && e.ph == 2'd2) begin
                stop = 1'b1;
                break;
            end
        end
        exp_q.delete();
        @(posedge clock); #1;
        stop = 1'b0;
        chk("stop", idle_e(1'b0));
        repeat (3) begin
            @(posedge clock); #1 chk("stop_idle", idle_e(1'b0));
        end

        // start and stop together in IDLE: stop wins
        apply_start(3, 3, 3, 1); stop = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; stop = 1'b0;
        chk("start_stop", idle_e(1'b0));
        repeat (2) begin
            @(posedge clock); #1 chk("start_stop_idle", idle_e(1'b0));
        end

        // Asynchronous reset in the middle of RED
        build(2, 2, 5, 1, 0); apply_start(2, 2, 5, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clock); #1;
            start = 1'b0;
            chk("pre_rst", e);
            if (e.ph == 2'd3 && e.tm == TW'(2)) break;
        end
        exp_q.delete();
        #3 reset_n = 1'b0;
        #1 chk("async_rst", idle_e(1'b0));
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1 chk("post_rst", idle_e(1'b0));
        build(1, 2, 3, 2, 0); apply_start(1, 2, 3, 2); run_q("after_rst", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
